// File: rtl/line_delay_buffer_if.sv
// Bundle of the delay buffer's stream, control and status signals.
// slave = buffer side, master = producer/consumer side.
interface line_delay_buffer_if #(
    parameter int DATA_W  = 40,
    parameter int DEPTH_W = 6
);
    logic               flush;
    logic [DEPTH_W-1:0] cfg_depth;
    logic               in_valid;
    logic [DATA_W-1:0]  data_in;
    logic               out_valid;
    logic [DATA_W-1:0]  data_out;
    logic               primed;
    logic [DEPTH_W-1:0] fill_count;

    modport slave (
        input  flush, cfg_depth, in_valid, data_in,
        output out_valid, data_out, primed, fill_count
    );

    modport master (
        output flush, cfg_depth, in_valid, data_in,
        input  out_valid, data_out, primed, fill_count
    );
endinterface

// File: rtl/line_delay_buffer.sv
// Delays a sample stream by a configurable number of accepted samples (circular buffer).
// Latency: one cycle from a primed accept to out_valid; idle cycles freeze all state, no backpressure.
module line_delay_buffer #(
    parameter int DATA_W        = 40,
    parameter int MAX_DEPTH     = 32,
    parameter int DEPTH_W       = 6,
    parameter int DEFAULT_DEPTH = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    line_delay_buffer_if.slave   bus
);

    localparam int               PTR_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [DEPTH_W:0] MAX_EXT  = (DEPTH_W + 1)'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] MAX_D  = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEF_D  = DEPTH_W'(DEFAULT_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_DEPTH - 1);

    typedef enum logic {ST_FILL, ST_PRIMED} state_t;

    state_t             r_state, w_state_nxt;
    logic [DEPTH_W-1:0] r_depth, r_fill;
    logic [DEPTH_W-1:0] w_cfg_clamped, w_fill_inc;
    logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_inc, w_rd_idx;
    logic [DEPTH_W:0]   w_rd_sum;
    logic [DATA_W-1:0]  r_mem [MAX_DEPTH];
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_data_out;
    logic               w_accept;

    assign w_accept     = bus.in_valid & ~bus.flush;
    assign w_fill_inc   = r_fill + DEPTH_W'(1);
    assign w_wr_ptr_inc = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);

    // Offset by MAX_DEPTH first so the subtraction never goes negative.
    assign w_rd_sum = (DEPTH_W + 1)'(r_wr_ptr) + MAX_EXT - {1'b0, r_depth};
    assign w_rd_idx = PTR_W'((w_rd_sum >= MAX_EXT) ? (w_rd_sum - MAX_EXT) : w_rd_sum);

    always_comb begin
        w_cfg_clamped = bus.cfg_depth;
        if (bus.cfg_depth == '0) begin
            w_cfg_clamped = DEPTH_W'(1);
        end else if (bus.cfg_depth > MAX_D) begin
            w_cfg_clamped = MAX_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = ST_FILL;
        end else if (bus.in_valid && r_state == ST_FILL && w_fill_inc == r_depth) begin
            w_state_nxt = ST_PRIMED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_depth     <= DEF_D;
            r_fill      <= '0;
            r_wr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else if (bus.flush) begin
            r_depth     <= w_cfg_clamped;
            r_fill      <= '0;
            r_wr_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            r_wr_ptr    <= w_wr_ptr_inc;
            r_out_valid <= (r_state == ST_PRIMED);
            if (r_state == ST_PRIMED) begin
                r_data_out <= r_mem[w_rd_idx];
            end else begin
                r_fill <= w_fill_inc;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Read above happens before this write, so a full-depth delay sees the old entry.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.data_out   = r_data_out;
    assign bus.primed     = (r_state == ST_PRIMED);
    assign bus.fill_count = r_fill;

endmodule

// File: tb/tb_line_delay_buffer.sv
// Scoreboard bench for line_delay_buffer: expected delayed samples are queued at drive time
// and popped whenever the buffer raises out_valid.
module tb_line_delay_buffer;

    localparam int DW = 40;
    localparam int MAXD = 32;

    logic clk = 1'b0;
    logic reset;

    line_delay_buffer_if #(.DATA_W(DW), .DEPTH_W(6)) ifc ();

    line_delay_buffer #(
        .DATA_W(DW), .MAX_DEPTH(MAXD), .DEPTH_W(6), .DEFAULT_DEPTH(23)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] m_hist [$];
    logic [DW-1:0] m_last_out;
    int            m_depth;
    int            m_fill;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int clamp_depth(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > MAXD) return MAXD;
        return cfg;
    endfunction

    // One clock: drive at negedge, update model at posedge, compare #1 later.
    task automatic cycle(input logic f, input int cfg, input logic v, input logic [DW-1:0] d);
        logic          exp_vld;
        logic [DW-1:0] e;
        @(negedge clk);
        ifc.flush     = f;
        ifc.cfg_depth = 6'(cfg);
        ifc.in_valid  = v;
        ifc.data_in   = d;
        @(posedge clk);
        exp_vld = 1'b0;
        if (f) begin
            m_depth = clamp_depth(cfg);
            m_fill  = 0;
            m_hist.delete();
        end else if (v) begin
            if (m_fill == m_depth) begin
                exp_q.push_back(m_hist[m_hist.size() - m_depth]);
                exp_vld = 1'b1;
            end else begin
                m_fill++;
            end
            m_hist.push_back(d);
        end
        #1;
        chk("out_valid", ifc.out_valid, exp_vld);
        if (ifc.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", ifc.data_out, e);
                m_last_out = e;
            end
        end else begin
            chk("data_hold", ifc.data_out, m_last_out);
        end
        chk("primed", ifc.primed, (m_fill == m_depth));
        chk("fill_count", ifc.fill_count, m_fill);
    endtask

    initial begin
        reset         = 1'b1;
        ifc.flush     = 1'b0;
        ifc.cfg_depth = '0;
        ifc.in_valid  = 1'b0;
        ifc.data_in   = '0;
        m_depth       = 23;
        m_fill        = 0;
        m_last_out    = '0;
        #22;
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_data_out", ifc.data_out, 0);
        chk("rst_primed", ifc.primed, 0);
        chk("rst_fill", ifc.fill_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Default depth 23: values 1..24, first output is 1 after the 24th accept.
        for (int k = 1; k <= 24; k++) cycle(1'b0, 0, 1'b1, DW'(k));
        chk("def_first_out", ifc.data_out, 1);

        // Depth 3 with idles between every accept.
        cycle(1'b1, 3, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 0, 1'b1, DW'(40'hA0 + k));
            cycle(1'b0, 0, 1'b0, '0);
            cycle(1'b0, 0, 1'b0, '0);
        end

        // Full depth across several pointer wraps.
        cycle(1'b1, MAXD, 1'b0, '0);
        for (int k = 0; k < 100; k++) cycle(1'b0, 0, 1'b1, DW'(40'h55_0000_0000 + k));

        // Clamps: 0 -> 1, 63 -> 32.
        cycle(1'b1, 0, 1'b0, '0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 0, 1'b1, DW'(40'hC0 + k));
        cycle(1'b1, 63, 1'b0, '0);
        for (int k = 0; k < 40; k++) cycle(1'b0, 0, (k % 5) != 4, DW'(40'hD00 + k));
        chk("sat_fill", ifc.fill_count, 32);

        // Flush with a valid sample in the same cycle drops that sample.
        cycle(1'b1, 4, 1'b1, DW'(40'hDEAD));
        for (int k = 0; k < 8; k++) cycle(1'b0, 0, 1'b1, DW'(40'hE0 + k));

        // Mid-cycle asynchronous reset while primed and outputting.
        ifc.in_valid = 1'b1;
        #3;
        ifc.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", ifc.out_valid, 0);
        chk("arst_data_out", ifc.data_out, 0);
        chk("arst_primed", ifc.primed, 0);
        chk("arst_fill", ifc.fill_count, 0);
        #1;
        reset      = 1'b0;
        m_depth    = 23;
        m_fill     = 0;
        m_last_out = '0;
        m_hist.delete();
        for (int k = 0; k < 25; k++) cycle(1'b0, 0, 1'b1, DW'(40'hF00 + k));

        // Random traffic with occasional flushes and arbitrary cfg_depth.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 24) == 0), int'($urandom_range(0, 63)),
                  ($urandom_range(0, 3) != 0), {8'($urandom), $urandom});
        end

        chk("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
